// File: rtl/axi_req_arbiter.sv
// AXI-MM cache front end: single-entry AR/AW/W holding registers, round-robin read vs write-beat
// arbitration, one 128-bit request word per access. Optional grant counters under AXI_ARB_STATS_EN.
module axi_req_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         s_arvalid,
  output logic         s_arready,
  input  logic [31:0]  s_araddr,
  input  logic [3:0]   s_arid,
  input  logic [1:0]   s_arburst,
  input  logic [2:0]   s_arsize,
  input  logic [7:0]   s_arlen,
  input  logic         s_awvalid,
  output logic         s_awready,
  input  logic [31:0]  s_awaddr,
  input  logic [3:0]   s_awid,
  input  logic [1:0]   s_awburst,
  input  logic [2:0]   s_awsize,
  input  logic [7:0]   s_awlen,
  input  logic         s_wvalid,
  output logic         s_wready,
  input  logic [63:0]  s_wdata,
  input  logic [7:0]   s_wstrb,
  input  logic         s_wlast,
  output logic         req_valid,
  input  logic         req_ready,
  output logic [127:0] result_arb,
  output logic         read_or_write
`ifdef AXI_ARB_STATS_EN
  ,
  output logic [15:0]  rd_grant_cnt,
  output logic [15:0]  wr_grant_cnt
`endif
);

  typedef struct packed {
    logic [6:0]  rsvd;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [31:0] addr;
  } req_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [7:0]  len;
  } cmd_t;

  logic        en;
  cmd_t        ar_q, aw_q;
  logic        ar_full, aw_full, w_full;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic [31:0] beat_addr, next_addr;
  logic        lock, rr_ptr;
  logic        ar_fire, aw_fire, w_fire;
  logic        rd_cand, wr_cand, can_load, gnt_rd, gnt_wr;
  logic [31:0] step, incr_addr, wrap_mask;
  req_t        rd_word, wr_word;

  // en keeps every ready low while reset is held and for the first edge after release
  assign s_arready = en & ~ar_full;
  assign s_awready = en & ~aw_full;
  assign s_wready  = aw_full & ~w_full;

  assign ar_fire = s_arvalid & s_arready;
  assign aw_fire = s_awvalid & s_awready;
  assign w_fire  = s_wvalid & s_wready;

  assign rd_cand  = ar_full;
  assign wr_cand  = aw_full & w_full;
  assign can_load = ~req_valid | req_ready;

  always_comb begin
    gnt_rd = 1'b0;
    gnt_wr = 1'b0;
    if (can_load) begin
      if (lock) begin
        gnt_wr = wr_cand;
      end else if (rd_cand && wr_cand) begin
        gnt_wr = rr_ptr;
        gnt_rd = ~rr_ptr;
      end else begin
        gnt_rd = rd_cand;
        gnt_wr = wr_cand;
      end
    end
  end

  // WRAP container is (len+1)<<size bytes; only the offset bits inside it advance
  assign step      = 32'd1 << aw_q.size;
  assign incr_addr = beat_addr + step;
  assign wrap_mask = (({24'd0, aw_q.len} + 32'd1) << aw_q.size) - 32'd1;

  always_comb begin
    case (aw_q.burst)
      2'b00:   next_addr = beat_addr;
      2'b10:   next_addr = (beat_addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
  end

  always_comb begin
    rd_word       = '0;
    rd_word.addr  = ar_q.addr;
    rd_word.id    = ar_q.id;
    rd_word.burst = ar_q.burst;
    rd_word.size  = ar_q.size;
    rd_word.len   = ar_q.len;
    wr_word       = '0;
    wr_word.addr  = beat_addr;
    wr_word.id    = aw_q.id;
    wr_word.burst = aw_q.burst;
    wr_word.size  = aw_q.size;
    wr_word.len   = aw_q.len;
    wr_word.wdata = w_data;
    wr_word.wstrb = w_strb;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) en <= 1'b0;
    else          en <= 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_full <= 1'b0;
      ar_q    <= '0;
    end else if (ar_fire) begin
      ar_full <= 1'b1;
      ar_q    <= '{s_araddr, s_arid, s_arburst, s_arsize, s_arlen};
    end else if (gnt_rd) begin
      ar_full <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full   <= 1'b0;
      aw_q      <= '0;
      beat_addr <= '0;
    end else if (aw_fire) begin
      aw_full   <= 1'b1;
      aw_q      <= '{s_awaddr, s_awid, s_awburst, s_awsize, s_awlen};
      beat_addr <= s_awaddr;
    end else if (gnt_wr) begin
      if (w_last) begin
        aw_full   <= 1'b0;
        beat_addr <= '0;
      end else begin
        beat_addr <= next_addr;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_full <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
      w_last <= 1'b0;
    end else if (w_fire) begin
      w_full <= 1'b1;
      w_data <= s_wdata;
      w_strb <= s_wstrb;
      w_last <= s_wlast;
    end else if (gnt_wr) begin
      w_full <= 1'b0;
    end
  end

  // lock holds reads off until the burst's wlast beat has been granted
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lock   <= 1'b0;
      rr_ptr <= RR_INIT;
    end else if (gnt_rd) begin
      rr_ptr <= 1'b1;
    end else if (gnt_wr) begin
      lock <= ~w_last;
      if (w_last) rr_ptr <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      req_valid     <= 1'b0;
      result_arb    <= '0;
      read_or_write <= 1'b0;
    end else if (gnt_rd) begin
      req_valid     <= 1'b1;
      result_arb    <= rd_word;
      read_or_write <= 1'b0;
    end else if (gnt_wr) begin
      req_valid     <= 1'b1;
      result_arb    <= wr_word;
      read_or_write <= 1'b1;
    end else if (req_ready) begin
      req_valid     <= 1'b0;
    end
  end

`ifdef AXI_ARB_STATS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_grant_cnt <= '0;
      wr_grant_cnt <= '0;
    end else begin
      if (gnt_rd && rd_grant_cnt != 16'hFFFF) rd_grant_cnt <= rd_grant_cnt + 16'd1;
      if (gnt_wr && wr_grant_cnt != 16'hFFFF) wr_grant_cnt <= wr_grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter: reset, read, INCR/WRAP writes, contention, backpressure,
// async reset mid-burst. Accepted requests are captured into a queue and checked against hand values.
module tb_axi_req_arbiter;

  logic         aclk, aresetn;
  logic         s_arvalid, s_arready;
  logic [31:0]  s_araddr;
  logic [3:0]   s_arid;
  logic [1:0]   s_arburst;
  logic [2:0]   s_arsize;
  logic [7:0]   s_arlen;
  logic         s_awvalid, s_awready;
  logic [31:0]  s_awaddr;
  logic [3:0]   s_awid;
  logic [1:0]   s_awburst;
  logic [2:0]   s_awsize;
  logic [7:0]   s_awlen;
  logic         s_wvalid, s_wready;
  logic [63:0]  s_wdata;
  logic [7:0]   s_wstrb;
  logic         s_wlast;
  logic         req_valid, req_ready;
  logic [127:0] result_arb;
  logic         read_or_write;

  int n_chk = 0;
  int n_fail = 0;
  logic [128:0] mon_q[$];

  axi_req_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arburst(s_arburst), .s_arsize(s_arsize), .s_arlen(s_arlen),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awburst(s_awburst), .s_awsize(s_awsize), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast),
    .req_valid(req_valid), .req_ready(req_ready), .result_arb(result_arb),
    .read_or_write(read_or_write)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(posedge aclk)
    if (aresetn && req_valid && req_ready) mon_q.push_back({read_or_write, result_arb});

  task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [128:0] mk(input bit rw, input logic [31:0] a, input logic [3:0] id,
                                      input logic [1:0] b, input logic [2:0] s, input logic [7:0] l,
                                      input logic [63:0] d, input logic [7:0] st);
    return {rw, 7'd0, st, d, l, s, b, id, a};
  endfunction

  task automatic check_q(input string tag, input int idx, input logic [128:0] exp);
    logic [128:0] v;
    v = (idx < mon_q.size()) ? mon_q[idx] : {129{1'b1}};
    check(tag, v, exp);
  endtask

  // all send tasks are entered on a negedge and return on a negedge
  task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [1:0] b,
                         input logic [2:0] s, input logic [7:0] l);
    int n;
    n = 0;
    s_araddr = a; s_arid = id; s_arburst = b; s_arsize = s; s_arlen = l; s_arvalid = 1'b1;
    while (!s_arready && n < 50) begin @(negedge aclk); n++; end
    check("ar_handshake", s_arready, 1'b1);
    @(posedge aclk); @(negedge aclk);
    s_arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [1:0] b,
                         input logic [2:0] s, input logic [7:0] l);
    int n;
    n = 0;
    s_awaddr = a; s_awid = id; s_awburst = b; s_awsize = s; s_awlen = l; s_awvalid = 1'b1;
    while (!s_awready && n < 50) begin @(negedge aclk); n++; end
    check("aw_handshake", s_awready, 1'b1);
    @(posedge aclk); @(negedge aclk);
    s_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] st, input logic last);
    int n;
    n = 0;
    s_wdata = d; s_wstrb = st; s_wlast = last; s_wvalid = 1'b1;
    while (!s_wready && n < 50) begin @(negedge aclk); n++; end
    check("w_handshake", s_wready, 1'b1);
    @(posedge aclk); @(negedge aclk);
    s_wvalid = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0; req_ready = 1'b0;
    s_arvalid = 0; s_araddr = 0; s_arid = 0; s_arburst = 0; s_arsize = 0; s_arlen = 0;
    s_awvalid = 0; s_awaddr = 0; s_awid = 0; s_awburst = 0; s_awsize = 0; s_awlen = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0;
    repeat (3) @(negedge aclk);
    check("rst_readies", {s_arready, s_awready, s_wready}, 3'b000);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_word", {read_or_write, result_arb}, 129'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_arready", s_arready, 1'b1);
    check("post_rst_wready", s_wready, 1'b0);

    // single read: valid one cycle after the AR handshake edge
    req_ready = 1'b1;
    send_ar(32'h0000_1040, 4'd3, 2'b01, 3'd3, 8'd0);
    check("rd_lat_not_yet", req_valid, 1'b0);
    check("rd_arready_full", s_arready, 1'b0);
    @(negedge aclk);
    check("rd_valid", req_valid, 1'b1);
    check("rd_addr", result_arb[31:0], 32'h1040);
    check("rd_id", result_arb[35:32], 4'd3);
    check("rd_data_zero", result_arb[120:49], 72'd0);
    check("rd_word", {read_or_write, result_arb}, mk(0, 32'h1040, 3, 1, 3, 0, 0, 0));
    @(negedge aclk);
    check("rd_consumed", req_valid, 1'b0);

    // INCR write burst
    mon_q.delete();
    send_aw(32'h100, 4'd1, 2'b01, 3'd3, 8'd3);
    check("incr_awready_busy", s_awready, 1'b0);
    for (int i = 0; i < 4; i++) send_w(64'hA + 64'(i), 8'hFF, i == 3);
    repeat (3) @(negedge aclk);
    check("incr_cnt", mon_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check_q("incr_beat", i, mk(1, 32'h100 + 32'(8 * i), 1, 1, 3, 3, 64'hA + 64'(i), 8'hFF));
    check("incr_awready_back", s_awready, 1'b1);

    // WRAP write burst: 32-byte container at 0x20
    mon_q.delete();
    send_aw(32'h38, 4'd4, 2'b10, 3'd3, 8'd3);
    for (int i = 0; i < 4; i++) send_w(64'h31 + 64'(i), 8'hF0, i == 3);
    repeat (3) @(negedge aclk);
    check("wrap_cnt", mon_q.size(), 4);
    check_q("wrap_b0", 0, mk(1, 32'h38, 4, 2, 3, 3, 64'h31, 8'hF0));
    check_q("wrap_b1", 1, mk(1, 32'h20, 4, 2, 3, 3, 64'h32, 8'hF0));
    check_q("wrap_b2", 2, mk(1, 32'h28, 4, 2, 3, 3, 64'h33, 8'hF0));
    check_q("wrap_b3", 3, mk(1, 32'h30, 4, 2, 3, 3, 64'h34, 8'hF0));

    // contention: read wins the tie, second AR waits out the locked burst
    mon_q.delete();
    fork
      begin
        send_aw(32'h300, 4'd2, 2'b01, 3'd2, 8'd1);
        send_w(64'h11, 8'h0F, 1'b0);
        repeat (3) @(negedge aclk);
        send_w(64'h22, 8'h0F, 1'b1);
      end
      begin
        @(negedge aclk);
        send_ar(32'h2000, 4'd5, 2'b01, 3'd3, 8'd0);
        send_ar(32'h3000, 4'd6, 2'b01, 3'd3, 8'd0);
      end
    join
    repeat (4) @(negedge aclk);
    check("cont_cnt", mon_q.size(), 4);
    check_q("cont_r1", 0, mk(0, 32'h2000, 5, 1, 3, 0, 0, 0));
    check_q("cont_w0", 1, mk(1, 32'h300, 2, 1, 2, 1, 64'h11, 8'h0F));
    check_q("cont_w1", 2, mk(1, 32'h304, 2, 1, 2, 1, 64'h22, 8'h0F));
    check_q("cont_r2", 3, mk(0, 32'h3000, 6, 1, 3, 0, 0, 0));

    // backpressure: output held stable, refilled ar_q blocks AR
    mon_q.delete();
    req_ready = 1'b0;
    send_ar(32'h6000, 4'd1, 2'b01, 3'd3, 8'd7);
    send_ar(32'h7000, 4'd2, 2'b01, 3'd3, 8'd0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", req_valid, 1'b1);
      check("bp_word", {read_or_write, result_arb}, mk(0, 32'h6000, 1, 1, 3, 7, 0, 0));
      check("bp_arready", s_arready, 1'b0);
      @(negedge aclk);
    end
    req_ready = 1'b1;
    repeat (4) @(negedge aclk);
    check("bp_cnt", mon_q.size(), 2);
    check_q("bp_a", 0, mk(0, 32'h6000, 1, 1, 3, 7, 0, 0));
    check_q("bp_b", 1, mk(0, 32'h7000, 2, 1, 3, 0, 0, 0));

    // asynchronous reset after first beat of a 4-beat burst
    req_ready = 1'b0;
    send_aw(32'h400, 4'd7, 2'b01, 3'd3, 8'd3);
    send_w(64'h1, 8'hFF, 1'b0);
    @(negedge aclk);
    check("mid_valid", {req_valid, read_or_write}, 2'b11);
    check("mid_addr", result_arb[31:0], 32'h400);
    #2 aresetn = 1'b0;
    #1;
    check("arst_valid", req_valid, 1'b0);
    check("arst_word", {read_or_write, result_arb}, 129'd0);
    check("arst_readies", {s_arready, s_awready, s_wready}, 3'b000);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("arst_after_ready", {s_arready, s_awready, s_wready}, 3'b110);
    req_ready = 1'b1;
    mon_q.delete();
    send_ar(32'h5000, 4'd9, 2'b01, 3'd2, 8'd0);
    repeat (3) @(negedge aclk);
    check("arst_fresh_cnt", mon_q.size(), 1);
    check_q("arst_fresh_rd", 0, mk(0, 32'h5000, 9, 1, 2, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
